// File: rtl/weight_read_sequencer.sv
// Streams one pass of (weight, feature) pairs from two registered-read memories
// to the neuron MAC through a 4-deep FIFO whose free space gates read issue.
module weight_read_sequencer #(
    parameter int NUM_WEIGHT = 30,
    parameter int ADDR_W     = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_radd,
    input  logic [DATA_W-1:0] w_rdata,
    input  logic [DATA_W-1:0] x_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_w,
    output logic [DATA_W-1:0] out_x,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                FIFO_DEPTH = 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_WEIGHT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_idx;

    logic [DATA_W-1:0] fifo_w   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_x   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_idx [FIFO_DEPTH];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_count;
    logic [2:0]        in_flight;
    logic              push;
    logic              pop;
    logic              drained_nxt;

    // Entries already stored plus the read still in the memory pipeline must
    // leave room for the read issued this cycle, so the FIFO can never overflow.
    assign in_flight = fifo_count + {2'b00, rd_pend};
    assign mem_ren   = (state == S_RUN) && (in_flight <= 3'd2);
    assign mem_radd  = addr;

    assign push = rd_pend;
    assign pop  = out_valid && out_ready;

    // FIFO will be empty after this edge with nothing left in the read pipeline.
    assign drained_nxt = !rd_pend &&
                         ((fifo_count == 3'd0) || ((fifo_count == 3'd1) && pop));

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (mem_ren && (addr == LAST_ADDR)) state_nxt = S_DRAIN;
            S_DRAIN: if (drained_nxt) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr    <= '0;
            rd_pend <= 1'b0;
            rd_idx  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && start) begin
                addr <= '0;
            end else if (mem_ren) begin
                addr <= addr + ADDR_W'(1);
            end
            rd_pend <= mem_ren;
            if (mem_ren) begin
                rd_idx <= addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the head is gated by out_valid so stale words never reach the MAC.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_w[wr_ptr]   <= w_rdata;
            fifo_x[wr_ptr]   <= x_rdata;
            fifo_idx[wr_ptr] <= rd_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (fifo_count < 3'(FIFO_DEPTH));
        end
    end

    assign out_valid = (fifo_count != 3'd0);
    assign out_w     = out_valid ? fifo_w[rd_ptr]   : '0;
    assign out_x     = out_valid ? fifo_x[rd_ptr]   : '0;
    assign out_idx   = out_valid ? fifo_idx[rd_ptr] : '0;
    assign out_last  = out_valid && (out_idx == LAST_ADDR);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Bench for weight_read_sequencer: directed pass scenarios with random ROM
// contents and random backpressure, checked against an expected-beat model.
module tb_weight_read_sequencer;

    localparam int N   = 30;
    localparam int AW  = $clog2(N);
    localparam int DW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, out_ready;
    logic          busy, done, mem_ren, out_valid, out_last;
    logic [AW-1:0] mem_radd, out_idx;
    logic [DW-1:0] w_rdata = '0, x_rdata = '0, out_w, out_x;

    logic          start1, ready1;
    logic          busy1, done1, mem_ren1, out_valid1, out_last1;
    logic [0:0]    mem_radd1, out_idx1;
    logic [DW-1:0] w_rdata1 = '0, x_rdata1 = '0, out_w1, out_x1;

    weight_read_sequencer #(.NUM_WEIGHT(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_radd(mem_radd), .w_rdata(w_rdata), .x_rdata(x_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w), .out_x(out_x),
        .out_idx(out_idx), .out_last(out_last)
    );

    weight_read_sequencer #(.NUM_WEIGHT(1), .DATA_W(DW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .mem_ren(mem_ren1), .mem_radd(mem_radd1), .w_rdata(w_rdata1), .x_rdata(x_rdata1),
        .out_valid(out_valid1), .out_ready(ready1), .out_w(out_w1), .out_x(out_x1),
        .out_idx(out_idx1), .out_last(out_last1)
    );

    // Registered-read memories shared-address models.
    logic [DW-1:0] rom_w [N];
    logic [DW-1:0] rom_x [N];

    always @(posedge clk) begin
        if (mem_ren) begin
            w_rdata <= rom_w[mem_radd];
            x_rdata <= rom_x[mem_radd];
        end
        if (mem_ren1) begin
            w_rdata1 <= 16'd100 + 16'(mem_radd1);
            x_rdata1 <= 16'd200 + 16'(mem_radd1);
        end
    end

    int tests = 0;
    int fails = 0;

    // Model state: next expected beat index and reads issued but not yet accepted.
    int            exp_k;
    int            occ;
    int            cyc = 0;
    int            lat_cyc = -1;
    int            first_valid_cyc;
    int            done_cyc;
    int            done_cnt;
    logic          prev_stall = 1'b0;
    logic          prev_last_acc = 1'b0;
    logic          prev_done = 1'b0;
    logic [DW-1:0] pw, px;
    logic [AW-1:0] pi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cycle(input logic rdy, input logic st);
        logic acc;
        logic last_now;
        out_ready = rdy;
        start     = st;
        @(negedge clk);
        cyc++;
        acc      = out_valid && out_ready;
        last_now = 1'b0;
        if (cyc == lat_cyc) begin
            chk("lat_busy", busy, 1);
            chk("lat_ren", mem_ren, 1);
            chk("lat_radd", mem_radd, 0);
        end
        chk("credit", mem_ren && (occ > 2), 0);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_w", out_w, pw);
            chk("hold_x", out_x, px);
            chk("hold_idx", out_idx, pi);
        end
        chk("done_timing", done, prev_last_acc);
        if (prev_done) chk("busy_after_done", busy, 0);
        if (done) begin
            chk("busy_in_done", busy, 1);
            done_cnt++;
            done_cyc = cyc;
        end
        if (acc) begin
            if (exp_k >= N) begin
                chk("extra_beat", out_valid, 0);
            end else begin
                chk("idx", out_idx, exp_k);
                chk("w", out_w, rom_w[exp_k]);
                chk("x", out_x, rom_x[exp_k]);
                chk("last", out_last, exp_k == N - 1);
                last_now = (exp_k == N - 1);
                exp_k++;
            end
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        occ = occ + int'(mem_ren) - int'(acc);
        if (occ > 4) chk("occ_max", occ, 4);
        prev_stall    = out_valid && !out_ready;
        pw            = out_w;
        px            = out_x;
        pi            = out_idx;
        prev_last_acc = last_now;
        prev_done     = done;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        occ           = 0;
        exp_k         = 0;
        lat_cyc       = -1;
        prev_stall    = 1'b0;
        prev_last_acc = 1'b0;
        prev_done     = 1'b0;
    endtask

    task automatic idle_checks(input int n);
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_ren", mem_ren, 0);
            @(posedge clk);
            #1;
        end
        prev_done = 1'b0;
    endtask

    // mode 0: ROM = addr+100/addr+200, ready always 1; mode 1: random ROM,
    // ready low in cycles 3..10 after start then 50% random.
    task automatic run_pass(input int mode, input int restart_idx, input int rst_idx);
        int   s;
        int   r;
        bit   pulsed;
        logic rdy, st;
        pulsed = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mode == 0) begin
                rom_w[i] = 16'(i + 100);
                rom_x[i] = 16'(i + 200);
            end else begin
                rom_w[i] = 16'($urandom);
                rom_x[i] = 16'($urandom);
            end
        end
        exp_k           = 0;
        done_cnt        = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
        s               = cyc + 1;
        lat_cyc         = s + 1;
        cycle(1'b1, 1'b1);
        for (int n = 0; n < 600 && done_cnt == 0; n++) begin
            if (rst_idx >= 0 && exp_k == rst_idx) break;
            r   = cyc + 1 - s;
            rdy = 1'b1;
            if (mode == 1) rdy = (r >= 3 && r <= 10) ? 1'b0 : 1'($urandom % 2);
            st = 1'b0;
            if (restart_idx >= 0 && !pulsed && exp_k == restart_idx) begin
                st     = 1'b1;
                pulsed = 1'b1;
            end
            cycle(rdy, st);
        end
        if (rst_idx >= 0) begin
            chk("rst_point", exp_k, rst_idx);
            chk("rst_no_done", done_cnt, 0);
            apply_reset();
            idle_checks(3);
        end else begin
            chk("pass_done_pulses", done_cnt, 1);
            chk("pass_beats", exp_k, N);
            if (restart_idx >= 0) chk("restart_seen", pulsed, 1);
            if (mode == 0) begin
                chk("first_valid", first_valid_cyc - s, 3);
                chk("no_bubble", done_cyc - first_valid_cyc, N);
            end
        end
    endtask

    initial begin
        int ren_cnt;
        bit got;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        start1    = 1'b0;
        ready1    = 1'b1;
        occ       = 0;
        exp_k     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_w", out_w, 0);
        chk("rst_x", out_x, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        @(posedge clk);
        #1;

        run_pass(0, -1, -1);
        run_pass(0, -1, -1);
        run_pass(1, -1, -1);
        run_pass(1, 12, -1);
        run_pass(0, -1, 15);
        run_pass(0, -1, -1);
        idle_checks(3);

        ren_cnt = 0;
        got     = 1'b0;
        start1  = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (mem_ren1) ren_cnt++;
            if (out_valid1) begin
                chk("n1_idx", out_idx1, 0);
                chk("n1_last", out_last1, 1);
                chk("n1_w", out_w1, 100);
                chk("n1_x", out_x1, 200);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("n1_beat_seen", got, 1);
        @(negedge clk);
        if (mem_ren1) ren_cnt++;
        chk("n1_done", done1, 1);
        chk("n1_valid_after", out_valid1, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("n1_done_end", done1, 0);
        chk("n1_busy_end", busy1, 0);
        chk("n1_ren_once", ren_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
